// File: rtl/mod32_seq_if.sv
// Start/done handshake and operand/result bus of the sequential remainder unit.
// The ALU control is the master; mod32_seq is the slave.
interface mod32_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             dbz;

    modport master (
        output start, a, b,
        input  busy, done, result, dbz
    );

    modport slave (
        input  start, a, b,
        output busy, done, result, dbz
    );
endinterface

// File: rtl/mod32_seq.sv
// mod32_seq: sequential a mod b by restoring shift-subtract, one quotient bit
// per clock. Feeds the Mod input (sel = 3'b111) of the ALU 8:1 result mux.
// FSM: IDLE -> CALC (WIDTH steps) -> DONE (one-cycle done pulse) -> IDLE.
// b == 0 skips CALC and returns a unchanged with dbz set.
// Optional feature: define MOD32_SIGNED_EN for two's-complement operands
// (remainder takes the sign of a, C semantics). Undefined: unsigned only.
module mod32_seq #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    mod32_seq_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] div_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] result_q;
    logic             dbz_q;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_step;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] rem_final;

`ifdef MOD32_SIGNED_EN
    logic a_neg_q;

    // Magnitude of a two's-complement value; the most-negative value maps to
    // 2^(WIDTH-1), which is exactly right when read back as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        logic signed [WIDTH-1:0] neg_v;
        neg_v = -v;
        return v[WIDTH-1] ? $unsigned(neg_v) : $unsigned(v);
    endfunction

    // Give the unsigned remainder the sign of the dividend.
    function automatic logic [WIDTH-1:0] sign_fix(input logic [WIDTH-1:0] mag,
                                                  input logic              neg);
        return neg ? (~mag + 1'b1) : mag;
    endfunction

    assign a_mag     = magnitude($signed(bus.a));
    assign b_mag     = magnitude($signed(bus.b));
    assign rem_final = sign_fix(rem_step[WIDTH-1:0], a_neg_q);
`else
    assign a_mag     = bus.a;
    assign b_mag     = bus.b;
    assign rem_final = rem_step[WIDTH-1:0];
`endif

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // The remainder is kept WIDTH+1 bits so a divisor with its MSB set cannot overflow.
    always_comb begin
        rem_sh   = (WIDTH+1)'({rem_q, dvd_q[WIDTH-1]});
        rem_step = rem_sh;
        if (rem_sh >= {1'b0, div_q}) begin
            rem_step = rem_sh - {1'b0, div_q};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = (bus.b == '0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        bus.busy = (state_q != S_IDLE);
        bus.done = (state_q == S_DONE);
    end

    assign bus.result = result_q;
    assign bus.dbz    = dbz_q;

    // Datapath: operand capture, shift-subtract iterations, result capture on DONE entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q    <= '0;
            dvd_q    <= '0;
            div_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            dbz_q    <= 1'b0;
`ifdef MOD32_SIGNED_EN
            a_neg_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.b == '0) begin
                            result_q <= bus.a;
                            dbz_q    <= 1'b1;
                        end else begin
                            rem_q   <= '0;
                            dvd_q   <= a_mag;
                            div_q   <= b_mag;
                            cnt_q   <= CW'(WIDTH - 1);
`ifdef MOD32_SIGNED_EN
                            a_neg_q <= bus.a[WIDTH-1];
`endif
                        end
                    end
                end
                S_CALC: begin
                    rem_q <= rem_step;
                    dvd_q <= dvd_q << 1;
                    if (cnt_q == '0) begin
                        result_q <= rem_final;
                        dbz_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mod32_seq.sv
// Scoreboard bench for mod32_seq: the driver pushes the expected remainder,
// dbz flag and done cycle computed with plain arithmetic; a separate monitor
// pops and compares whenever done is high.
module tb_mod32_seq;
    localparam int WIDTH = 32;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             dbz;
        int unsigned      cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    mod32_seq_if #(.WIDTH(WIDTH)) bus ();

    mod32_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t             sb_q[$];
    int               n_checks = 0;
    int               n_fail   = 0;
    logic [WIDTH-1:0] held_res = '0;
    logic             held_dbz = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: remainder from arithmetic on 64-bit integers, done cycle from latency.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input int unsigned start_cyc);
        exp_t e;
        if (b == '0) begin
            e.res = a;
            e.dbz = 1'b1;
            e.cyc = start_cyc + 1;
        end else begin
`ifdef MOD32_SIGNED_EN
            longint sa, sb, r;
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            if (sa < 0) sa = -sa;
            if (sb < 0) sb = -sb;
            r = sa % sb;
            if (a[WIDTH-1]) r = -r;
            e.res = r[WIDTH-1:0];
`else
            e.res = a % b;
`endif
            e.dbz = 1'b0;
            e.cyc = start_cyc + WIDTH + 1;
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && bus.done) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: done=1 with nothing outstanding (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("result", 64'(bus.result), 64'(e.res));
                chk("dbz", 64'(bus.dbz), 64'(e.dbz));
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
                chk("busy_in_done", 64'(bus.busy), 64'd1);
            end
        end
    end

    // Wait for IDLE, check the held result, issue one operation, optionally
    // re-pulse start with other operands while the unit is busy.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit junk);
        int   t;
        exp_t e;
        t = 0;
        while (bus.busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: busy stuck at %0b", bus.busy);
            return;
        end
        chk("result_held", 64'(bus.result), 64'(held_res));
        chk("dbz_held", 64'(bus.dbz), 64'(held_dbz));
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        e = model(a, b, cyc);
        sb_q.push_back(e);
        held_res = e.res;
        held_dbz = e.dbz;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        if (junk) begin
            repeat ($urandom_range(1, 5)) @(negedge clk);
            if (bus.busy) begin
                bus.start = 1'b1;
                bus.a     = 1;
                bus.b     = 1;
                @(negedge clk);
                bus.start = 1'b0;
            end
        end
    endtask

    initial begin
        int t;
        logic [WIDTH-1:0] ra, rb;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_result", 64'(bus.result), 64'd0);
        chk("reset_dbz", 64'(bus.dbz), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed cases, including boundaries.
        do_op(32'd100, 32'd7, 1'b0);
        do_op(32'hFFFF_FFFF, 32'h10, 1'b0);
        do_op(32'd3, 32'h8000_0001, 1'b0);
        do_op(32'd5, 32'd0, 1'b0);
        do_op(32'd9, 32'd4, 1'b0);
        do_op(32'd100, 32'd7, 1'b1);
        do_op(32'hFFFF_FFF9, 32'd3, 1'b0);
        do_op(32'd6, 32'd11, 1'b0);
        do_op(32'h1234_5678, 32'd1, 1'b0);
        do_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op(32'h8000_0000, 32'h8000_0000, 1'b0);
        do_op(32'h8000_0000, 32'd0, 1'b0);

        // Reset in the middle of CALC aborts the operation with no done pulse.
        do_op(32'd100, 32'd7, 1'b0);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        sb_q.delete();
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_result", 64'(bus.result), 64'd0);
        chk("abort_dbz", 64'(bus.dbz), 64'd0);
        reset    = 1'b0;
        held_res = '0;
        held_dbz = 1'b0;
        repeat (40) @(negedge clk);
        do_op(32'd9, 32'd4, 1'b0);

        // Randomised operations.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 4))
                0:       rb = '0;
                1:       rb = WIDTH'($urandom_range(1, 16));
                2:       rb = $urandom;
                3:       rb = {1'b1, 31'($urandom)};
                default: rb = ra >> $urandom_range(0, 3);
            endcase
            do_op(ra, rb, 1'($urandom_range(0, 1)));
        end

        t = 0;
        while ((sb_q.size() != 0 || bus.busy) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("outstanding_at_end", 64'(sb_q.size()), 64'd0);
        chk("final_result_held", 64'(bus.result), 64'(held_res));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
